// File: rtl/led_breath_sched.sv
// led_breath_sched: one shared breathing-PWM engine sequenced across
// N_LED outputs, round-robin or in unison, with a valid/ready mode port.
module led_breath_sched #(
  parameter int N_LED        = 4,
  parameter int CNT_TICK_MAX = 49,
  parameter int PWM_STEPS    = 1000,
  localparam int IDX_W = (N_LED > 1) ? $clog2(N_LED) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_mode,
  output logic             cmd_ready,
  output logic [N_LED-1:0] led_o,
  output logic [IDX_W-1:0] active_idx_o,
  output logic             busy_o,
  output logic             cycle_done_o
);

  localparam int TICK_W =
    (CNT_TICK_MAX > 0) ? $clog2(CNT_TICK_MAX + 1) : 1;
  localparam int DUTY_W =
    (PWM_STEPS > 1) ? $clog2(PWM_STEPS) : 1;

  localparam logic [TICK_W-1:0] TICK_END = TICK_W'(CNT_TICK_MAX);
  localparam logic [DUTY_W-1:0] STEP_END = DUTY_W'(PWM_STEPS - 1);
  localparam logic [IDX_W-1:0]  IDX_END  = IDX_W'(N_LED - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RISE,
    S_FALL,
    S_NEXT
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [DUTY_W-1:0] pwm_q, pwm_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [N_LED-1:0]  led_q, led_d;

  logic run;
  logic tick;
  logic pend;
  logic on;

  assign run  = (state_q == S_RISE) || (state_q == S_FALL);
  assign tick = run && (tick_q == TICK_END);
  assign pend = tick && (pwm_q == STEP_END);
  assign on   = (pwm_q < duty_q);

  assign cmd_ready    = (state_q == S_IDLE);
  assign busy_o       = (state_q != S_IDLE);
  assign led_o        = led_q;
  assign active_idx_o = (mode_q == 2'd1) ? '0 : idx_q;
  // Only modes 0/1 reach NEXT, so mode_q[0] selects unison.
  assign cycle_done_o = (state_q == S_NEXT) &&
                        (mode_q[0] || (idx_q == IDX_END));

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    tick_d  = '0;
    pwm_d   = '0;
    duty_d  = duty_q;
    idx_d   = idx_q;

    if (run) begin
      tick_d = tick ? '0 : tick_q + 1'b1;
      pwm_d  = pwm_q;
      if (tick) begin
        pwm_d = (pwm_q == STEP_END) ? '0 : pwm_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        duty_d = '0;
        if (cmd_valid) begin
          mode_d = cmd_mode;
        end
        if (en && !mode_q[1]) begin
          state_d = S_RISE;
        end
      end
      S_RISE: begin
        if (pend) begin
          if (duty_q == STEP_END) begin
            state_d = S_FALL;
          end else begin
            duty_d = duty_q + 1'b1;
          end
        end
      end
      S_FALL: begin
        if (pend) begin
          if (duty_q == '0) begin
            state_d = S_NEXT;
          end else begin
            duty_d = duty_q - 1'b1;
          end
        end
      end
      S_NEXT: begin
        duty_d = '0;
        if (mode_q[0]) begin
          idx_d = '0;
        end else begin
          idx_d = (idx_q == IDX_END) ? '0 : idx_q + 1'b1;
        end
        state_d = en ? S_RISE : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    led_d = '0;
    if (run && mode_q == 2'd1) begin
      led_d = {N_LED{on}};
    end else if (run && mode_q == 2'd0) begin
      for (int i = 0; i < N_LED; i++) begin
        led_d[i] = on && (idx_q == IDX_W'(i));
      end
    end else if (state_q == S_IDLE && mode_q == 2'd3) begin
      led_d = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= 2'd2;
      tick_q  <= '0;
      pwm_q   <= '0;
      duty_q  <= '0;
      idx_q   <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      tick_q  <= tick_d;
      pwm_q   <= pwm_d;
      duty_q  <= duty_d;
      idx_q   <= idx_d;
      led_q   <= led_d;
    end
  end

endmodule

// File: doc/led_breath_sched.md
# led_breath_sched

Scheduler that time-shares one breathing-PWM engine across `N_LED` LEDs on the 25 MHz board clock. It owns the shared 2 µs tick, the 1000-step PWM counter and the duty ramp. It sequences "breaths" (a full rise followed by a full fall) either round-robin, one LED at a time, or in unison on all LEDs. A mode command is accepted over a valid/ready handshake. The block sits between the board-control logic (mode and enable) and the LED pins.

## Interface
- `N_LED`, 4: number of LED outputs; `active_idx_o` width is `IDX_W = clog2(N_LED)` (min 1).
- `CNT_TICK_MAX`, 49: tick divider terminal count; tick period is `CNT_TICK_MAX+1` clk (2 µs at 25 MHz).
- `PWM_STEPS`, 1000: PWM period in ticks; also the number of duty levels, 0..`PWM_STEPS-1`.
- `clk` in 1: clock, 25 MHz.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: level. 1 means run breaths in breathing modes; 0 means stop gracefully.
- `cmd_valid` in 1: mode command valid.
- `cmd_mode` in 2: 0 = round-robin breathe, 1 = unison breathe, 2 = all off, 3 = all on.
- `cmd_ready` out 1: high exactly when FSM is IDLE.
- `led_o` out `N_LED`: LED drive, registered.
- `active_idx_o` out `IDX_W`: LED currently breathing (round-robin); 0 in unison mode.
- `busy_o` out 1: high in RISE, FALL and NEXT.
- `cycle_done_o` out 1: one-clk pulse at end of a full pass.

## Operation
- **Mode register.** Reset value 2 (off). Loaded from `cmd_mode` on the clk where `cmd_valid && cmd_ready`. Commands offered while not IDLE wait; `cmd_valid` may stay high.
- **Timebase.** Counters run only in RISE and FALL; they are forced to 0 in IDLE and NEXT.
  - `tick_cnt` counts 0..`CNT_TICK_MAX` and wraps.
  - `tick = (tick_cnt == CNT_TICK_MAX)`.
  - `pwm_cnt` counts 0..`PWM_STEPS-1` and advances on `tick`.
  - `pend = tick && pwm_cnt == PWM_STEPS-1` (period end).
- **Duty.** Width `clog2(PWM_STEPS)`. Cleared to 0 on IDLE→RISE and NEXT→RISE. Changes only on `pend`.
- **FSM transitions.**
  - IDLE → RISE when `en && mode ∈ {0,1}`. A mode loaded this clk takes effect next clk.
  - RISE, on `pend`: if `duty == PWM_STEPS-1`, go to FALL with duty held; else `duty+1`.
  - FALL, on `pend`: if `duty == 0`, go to NEXT; else `duty-1`.
  - NEXT (1 clk):
    - Mode 0: `active_idx` wraps `N_LED-1` → 0, else increments. `cycle_done_o` pulses when wrapping.
    - Mode 1: `active_idx` stays 0 and `cycle_done_o` pulses every NEXT.
    - Then → RISE if `en`, else → IDLE.
- **Graceful stop.** `en` falling mid-RISE or mid-FALL does not abort. The breath completes through FALL, then NEXT, then IDLE. `active_idx` is retained in IDLE and resumes from there.
- **LED drive** (registered, next clk):
  - RISE or FALL, mode 0: `led_o[i] = (i == active_idx) && (pwm_cnt < duty)`.
  - RISE or FALL, mode 1: all bits `= (pwm_cnt < duty)`.
  - IDLE, mode 3: all ones.
  - Otherwise: 0.
  - `duty == 0` means fully dark. `duty == PWM_STEPS-1` means on for `PWM_STEPS-1` of `PWM_STEPS` ticks.
- **Reset.** Asynchronous to IDLE from any state, with:
  - `led_o = 0`, `active_idx_o = 0`, `busy_o = 0`, `cycle_done_o = 0`, `cmd_ready = 1`, mode = 2.
  - All counters 0.

## Timing
- Period `P = PWM_STEPS*(CNT_TICK_MAX+1)` clk; defaults give 50,000 clk = 2 ms.
- RISE = `PWM_STEPS` periods and FALL = `PWM_STEPS` periods; 2 s each by default.
- Per-LED breath = `2*PWM_STEPS*P + 1` clk, including NEXT.
- `led_o` lags the (`pwm_cnt`, `duty`, state) compare by 1 clk.
- Leaving IDLE: `busy_o` and `cmd_ready` change 1 clk after the IDLE→RISE decision.
- Returning: `busy_o` and `cmd_ready` change on the clk after NEXT.
- Mode 3→2 change in IDLE: `led_o` follows 1 clk after handshake clk plus 1 (mode register, then LED register).

## Test plan
All scenarios use `CNT_TICK_MAX=1`, `PWM_STEPS=4`, `N_LED=4` (P = 8 clk, breath = 65 clk).

- **Round-robin.** Reset; cmd mode 0 accepted; `en=1`.
  - `active_idx_o` steps 0,1,2,3,0 every 65 clk.
  - Only the indexed `led_o` bit ever toggles.
  - `cycle_done_o` is a single pulse on the 4th NEXT (clk 260 after RISE entry).
- **Duty profile.** Mode 1, `en=1`.
  - Per period, high-clk count on each `led_o` bit is 0,2,4,6 during RISE, then 6,4,2,0 during FALL.
  - All 4 bits are identical.
  - `cycle_done_o` pulses every 65 clk.
- **Graceful stop.** Drop `en` mid-RISE of LED 1.
  - FALL completes; `active_idx` becomes 2; FSM goes to IDLE.
  - `led_o = 0`, `busy_o = 0`, `cmd_ready = 1`.
  - Re-raising `en` breathes LED 2 first.
- **Handshake hold-off.** `cmd_valid=1`, mode 3 asserted while busy.
  - No load until IDLE.
  - Load clk is the first clk with `cmd_ready=1`.
  - `led_o = 4'b1111` afterward and stays static.
- **Static off.** After reset with no command and `en=1`: FSM stays IDLE, `led_o = 0`, `busy_o = 0`.
- **Reset mid-operation.** Assert `rst_n=0` mid-FALL.
  - All outputs are at reset values immediately.
  - After release, mode is 2 and nothing runs until a new command.
